tmr_sipo_receiver: RTL and testbench

//  Triplicated serial-to-parallel receiver; receiving end of the serial stream emitted by the TMR shift register.

---
 rtl/tmr_rx_pkg.sv | 27 ++
 rtl/sipo_lane.sv | 120 ++++++++++++
 rtl/tmr_sipo_receiver.sv | 108 ++++++++++
 tb/tb_tmr_sipo_receiver.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_rx_pkg.sv
// Shared types and helpers for the triplicated serial-to-parallel receiver.
// maj3 votes on fields up to MAJ_W bits wide; callers zero-extend and truncate.
package tmr_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int MAJ_W         = 64;
    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

    function automatic logic [MAJ_W-1:0] maj3(
        input logic [MAJ_W-1:0] a,
        input logic [MAJ_W-1:0] b,
        input logic [MAJ_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sipo_lane.sv
// One replica of the receiver: shift register, bit counter, FSM, bit-order latch,
// holding register, valid and overrun flags. Next state comes from the vote when this replica disagrees.
module sipo_lane
    import tmr_rx_pkg::*;
#(
    parameter int width = 4,
    parameter int cnt_w = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             msb_first,
    input  logic             out_ready,
    input  logic             disagree,
    input  logic [width-1:0] v_sr,
    input  logic [cnt_w-1:0] v_cnt,
    input  rx_state_t        v_state,
    input  logic             v_msb,
    input  logic [width-1:0] v_hold,
    input  logic             v_valid,
    output logic [width-1:0] sr,
    output logic [cnt_w-1:0] cnt,
    output rx_state_t        state,
    output logic             msb,
    output logic [width-1:0] hold,
    output logic             valid,
    output logic             overrun
);

    localparam logic [cnt_w-1:0] LAST_BIT = cnt_w'(width - 1);

    logic [width-1:0] sr_reg, sr_next, src_sr, shifted;
    logic [width-1:0] hold_reg, hold_next, src_hold;
    logic [cnt_w-1:0] cnt_reg, cnt_next, src_cnt, cnt_eff;
    rx_state_t        state_reg, state_next, src_state;
    logic             msb_reg, msb_next, src_msb, msb_eff;
    logic             valid_reg, valid_next, src_valid;
    logic             overrun_reg, overrun_next;
    logic             start, sample, complete;

    always_comb begin
        src_sr    = disagree ? v_sr    : sr_reg;
        src_cnt   = disagree ? v_cnt   : cnt_reg;
        src_state = disagree ? v_state : state_reg;
        src_msb   = disagree ? v_msb   : msb_reg;
        src_hold  = disagree ? v_hold  : hold_reg;
        src_valid = disagree ? v_valid : valid_reg;

        // A frame_start always restarts at bit 0, aborting any partial frame.
        start    = enable & frame_start;
        sample   = enable & (frame_start | (src_state == SHIFT));
        msb_eff  = start ? msb_first : src_msb;
        cnt_eff  = start ? '0 : src_cnt;
        shifted  = msb_eff ? {src_sr[width-2:0], serial_in}
                           : {serial_in, src_sr[width-1:1]};
        complete = sample & (cnt_eff == LAST_BIT);

        sr_next      = src_sr;
        cnt_next     = src_cnt;
        state_next   = src_state;
        msb_next     = src_msb;
        hold_next    = src_hold;
        valid_next   = src_valid;
        overrun_next = 1'b0;

        if (sample) begin
            sr_next  = shifted;
            msb_next = msb_eff;
            if (complete) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                state_next = SHIFT;
                cnt_next   = cnt_eff + 1'b1;
            end
        end

        // A completed word may load when the holder is empty or being drained this cycle.
        if (complete && (!src_valid || out_ready)) begin
            hold_next  = shifted;
            valid_next = 1'b1;
        end else begin
            overrun_next = complete;
            if (src_valid && out_ready) begin
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg      <= '0;
            cnt_reg     <= '0;
            state_reg   <= IDLE;
            msb_reg     <= 1'b0;
            hold_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            sr_reg      <= sr_next;
            cnt_reg     <= cnt_next;
            state_reg   <= state_next;
            msb_reg     <= msb_next;
            hold_reg    <= hold_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign sr      = sr_reg;
    assign cnt     = cnt_reg;
    assign state   = state_reg;
    assign msb     = msb_reg;
    assign hold    = hold_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/tmr_sipo_receiver.sv
// Triplicated SIPO receiver: three sipo_lane replicas, bitwise majority voting and scrubbing.
// Define TMR_FAULT_FLAG_EN to add the registered fault output.
module tmr_sipo_receiver
    import tmr_rx_pkg::*;
#(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             msb_first,
    input  logic             out_ready,
    output logic [width-1:0] parallel_out,
    output logic             valid,
    output logic             overrun
`ifdef TMR_FAULT_FLAG_EN
    ,
    output logic             fault
`endif
);

    localparam int CNT_W = cnt_width(width);

    logic [width-1:0] sr_l      [3];
    logic [CNT_W-1:0] cnt_l     [3];
    rx_state_t        state_l   [3];
    logic             msb_l     [3];
    logic [width-1:0] hold_l    [3];
    logic             valid_l   [3];
    logic             overrun_l [3];
    logic [2:0]       disagree;

    logic [width-1:0] sr_v, hold_v;
    logic [CNT_W-1:0] cnt_v;
    rx_state_t        state_v;
    logic             msb_v, valid_v, overrun_v;

    assign sr_v      = width'(maj3(MAJ_W'(sr_l[0]), MAJ_W'(sr_l[1]), MAJ_W'(sr_l[2])));
    assign cnt_v     = CNT_W'(maj3(MAJ_W'(cnt_l[0]), MAJ_W'(cnt_l[1]), MAJ_W'(cnt_l[2])));
    assign state_v   = rx_state_t'(1'(maj3(MAJ_W'(state_l[0]), MAJ_W'(state_l[1]),
                                          MAJ_W'(state_l[2]))));
    assign msb_v     = 1'(maj3(MAJ_W'(msb_l[0]), MAJ_W'(msb_l[1]), MAJ_W'(msb_l[2])));
    assign hold_v    = width'(maj3(MAJ_W'(hold_l[0]), MAJ_W'(hold_l[1]), MAJ_W'(hold_l[2])));
    assign valid_v   = 1'(maj3(MAJ_W'(valid_l[0]), MAJ_W'(valid_l[1]), MAJ_W'(valid_l[2])));
    assign overrun_v = 1'(maj3(MAJ_W'(overrun_l[0]), MAJ_W'(overrun_l[1]),
                               MAJ_W'(overrun_l[2])));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            assign disagree[gi] = (sr_l[gi]      != sr_v)    |
                                  (cnt_l[gi]     != cnt_v)   |
                                  (state_l[gi]   != state_v) |
                                  (msb_l[gi]     != msb_v)   |
                                  (hold_l[gi]    != hold_v)  |
                                  (valid_l[gi]   != valid_v) |
                                  (overrun_l[gi] != overrun_v);

            sipo_lane #(
                .width (width),
                .cnt_w (CNT_W)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .enable      (enable),
                .serial_in   (serial_in),
                .frame_start (frame_start),
                .msb_first   (msb_first),
                .out_ready   (out_ready),
                .disagree    (disagree[gi]),
                .v_sr        (sr_v),
                .v_cnt       (cnt_v),
                .v_state     (state_v),
                .v_msb       (msb_v),
                .v_hold      (hold_v),
                .v_valid     (valid_v),
                .sr          (sr_l[gi]),
                .cnt         (cnt_l[gi]),
                .state       (state_l[gi]),
                .msb         (msb_l[gi]),
                .hold        (hold_l[gi]),
                .valid       (valid_l[gi]),
                .overrun     (overrun_l[gi])
            );
        end
    endgenerate

    assign parallel_out = hold_v;
    assign valid        = valid_v;
    assign overrun      = overrun_v;

`ifdef TMR_FAULT_FLAG_EN
    logic fault_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= |disagree;
        end
    end

    assign fault = fault_reg;
`endif

endmodule

// File: tb/tb_tmr_sipo_receiver.sv
// Bench for tmr_sipo_receiver (width 4): directed scenarios plus random traffic
// compared against a frame-level model; fault injection via force on one replica.
`timescale 1ns/1ps
module tb_tmr_sipo_receiver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, enable, serial_in, frame_start, msb_first, out_ready;
    logic [W-1:0] parallel_out;
    logic         valid, overrun;
`ifdef TMR_FAULT_FLAG_EN
    logic         fault;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Frame-level model: list of collected bits, then word assembly by bit order.
    bit           m_active = 1'b0;
    int           m_n      = 0;
    bit           m_bits [W];
    bit           m_msb    = 1'b0;
    logic [W-1:0] m_hold   = '0;
    bit           m_valid  = 1'b0;
    bit           m_over   = 1'b0;

    logic [W-1:0] inj_sr;
    logic         inj_v;
    int           fault_cnt;

    always #5 clk = ~clk;

    tmr_sipo_receiver #(.width(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .serial_in    (serial_in),
        .frame_start  (frame_start),
        .msb_first    (msb_first),
        .out_ready    (out_ready),
        .parallel_out (parallel_out),
        .valid        (valid),
        .overrun      (overrun)
`ifdef TMR_FAULT_FLAG_EN
        ,
        .fault        (fault)
`endif
    );

    task automatic model_step();
        logic [W-1:0] word = '0;
        bit           done = 1'b0;
        if (rst) begin
            m_active = 1'b0; m_n = 0; m_hold = '0; m_valid = 1'b0; m_over = 1'b0;
            return;
        end
        if (enable && frame_start) begin
            m_active = 1'b1; m_n = 0; m_msb = msb_first;
        end
        if (enable && m_active) begin
            m_bits[m_n] = serial_in;
            m_n++;
            if (m_n == W) begin
                done = 1'b1; m_active = 1'b0; m_n = 0;
                for (int i = 0; i < W; i++) word[m_msb ? W - 1 - i : i] = m_bits[i];
            end
        end
        m_over = 1'b0;
        if (done && m_valid && !out_ready) m_over = 1'b1;
        else if (done) begin
            m_hold = word; m_valid = 1'b1;
        end else if (m_valid && out_ready) m_valid = 1'b0;
    endtask

    task automatic drive(input logic r, input logic en, input logic si, input logic fs,
                         input logic mf, input logic rdy);
        rst = r; enable = en; serial_in = si; frame_start = fs; msb_first = mf; out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    // b[i] is the i-th bit presented on serial_in.
    task automatic send_frame(input logic [W-1:0] b, input logic mf, input logic rdy);
        for (int i = 0; i < W; i++) drive(1'b0, 1'b1, b[i], i == 0, mf, rdy);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (parallel_out !== 4'b0000 || valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%b v=%b ov=%b, want 0000 0 0", parallel_out, valid, overrun);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (parallel_out !== 4'b0000 || valid !== 1'b0 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_midframe: got out=%b v=%b ov=%b, want 0000 0 0", parallel_out, valid, overrun);
        end
        send_frame(4'b1110, 1'b0, 1'b1);
        vectors++;
        if (parallel_out !== 4'b1110 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_next_frame: got out=%b v=%b, want 1110 1", parallel_out, valid);
        end
        $display("test_reset: word %b after mid-frame reset", parallel_out);
    endtask

    task automatic test_lsb_first();
        idle(2, 1'b1);
        send_frame(4'b1101, 1'b0, 1'b1);
        vectors++;
        if (parallel_out !== 4'b1101 || valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_word: got out=%b v=%b ov=%b, want 1101 1 0", parallel_out, valid, overrun);
        end
        $display("test_lsb_first: word %b", parallel_out);
        idle(1, 1'b1);
        vectors++;
        if (valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_valid_drop: got v=%b, want 0", valid);
        end
    endtask

    task automatic test_msb_first();
        idle(2, 1'b1);
        send_frame(4'b1101, 1'b1, 1'b1);
        vectors++;
        if (parallel_out !== 4'b1011 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_word: got out=%b v=%b, want 1011 1", parallel_out, valid);
        end
        $display("test_msb_first: word %b", parallel_out);
        idle(2, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'b1, 1'b0, 1'b1);
            vectors++;
            if (valid !== 1'b0) begin
                miscompares++;
                $display("FAIL msb_gap_%0d: got v=%b, want 0", i, valid);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        vectors++;
        if (parallel_out !== 4'b1011 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL msb_gap_word: got out=%b v=%b, want 1011 1", parallel_out, valid);
        end
        $display("test_msb_first: word %b after 3-cycle enable gap", parallel_out);
    endtask

    task automatic test_backpressure();
        idle(2, 1'b1);
        send_frame(4'b0011, 1'b0, 1'b0);
        vectors++;
        if (parallel_out !== 4'b0011 || valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_first: got out=%b v=%b ov=%b, want 0011 1 0", parallel_out, valid, overrun);
        end
        send_frame(4'b1100, 1'b0, 1'b0);
        vectors++;
        if (parallel_out !== 4'b0011 || valid !== 1'b1 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_overrun: got out=%b v=%b ov=%b, want 0011 1 1", parallel_out, valid, overrun);
        end
        idle(1, 1'b0);
        vectors++;
        if (parallel_out !== 4'b0011 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_overrun_pulse: got out=%b ov=%b, want 0011 0", parallel_out, overrun);
        end
        for (int i = 0; i < W; i++) drive(1'b0, 1'b1, 1'((4'b1010 >> i) & 1), i == 0, 1'b0, i == W - 1);
        vectors++;
        if (parallel_out !== 4'b1010 || valid !== 1'b1 || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_swap: got out=%b v=%b ov=%b, want 1010 1 0", parallel_out, valid, overrun);
        end
        $display("test_backpressure: word %b presented after simultaneous transfer", parallel_out);
        idle(1, 1'b1);
    endtask

    task automatic test_restart();
        bit seq [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        idle(2, 1'b1);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, seq[i], (i == 0) || (i == 3), 1'b0, 1'b1);
            vectors++;
            if (i < 6 && valid !== 1'b0) begin
                miscompares++;
                $display("FAIL restart_aborted_%0d: got v=%b out=%b, want v=0", i, valid, parallel_out);
            end else if (i == 6 && (valid !== 1'b1 || parallel_out !== 4'b0110)) begin
                miscompares++;
                $display("FAIL restart_word: got out=%b v=%b, want 0110 1", parallel_out, valid);
            end
        end
        $display("test_restart: word %b", parallel_out);
    endtask

    task automatic test_random();
        int words = 0;
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(99) == 0, $urandom_range(99) < 85, 1'($urandom_range(1)),
                  $urandom_range(99) < 15, 1'($urandom_range(1)), 1'($urandom_range(1)));
            if (valid === 1'b1 && out_ready === 1'b1) words++;
            vectors++;
            if (parallel_out !== m_hold || valid !== m_valid || overrun !== m_over) begin
                miscompares++;
                $display("FAIL random_cyc%0d: got out=%b v=%b ov=%b, want out=%b v=%b ov=%b",
                         c, parallel_out, valid, overrun, m_hold, m_valid, m_over);
            end
        end
        $display("test_random: 800 cycles, about %0d words offered", words);
    endtask

    task automatic test_fault_injection();
        idle(2, 1'b1);
        send_frame(4'b1001, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                inj_sr = ~m_hold;
                force dut.g_lane[1].u_lane.sr_reg = inj_sr;
            end else begin
                inj_v = ~m_valid;
                force dut.g_lane[2].u_lane.valid_reg = inj_v;
            end
            #1;
            vectors++;
            if (parallel_out !== m_hold || valid !== m_valid || overrun !== m_over) begin
                miscompares++;
                $display("FAIL fault%0d_outputs_forced: got out=%b v=%b ov=%b, want out=%b v=%b ov=%b",
                         k, parallel_out, valid, overrun, m_hold, m_valid, m_over);
            end
            if (k == 0) release dut.g_lane[1].u_lane.sr_reg;
            else        release dut.g_lane[2].u_lane.valid_reg;
            fault_cnt = 0;
            for (int c = 0; c < 3; c++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TMR_FAULT_FLAG_EN
                if (fault === 1'b1) fault_cnt++;
`endif
                vectors++;
                if (parallel_out !== m_hold || valid !== m_valid || overrun !== m_over) begin
                    miscompares++;
                    $display("FAIL fault%0d_outputs_cyc%0d: got out=%b v=%b ov=%b, want out=%b v=%b ov=%b",
                             k, c, parallel_out, valid, overrun, m_hold, m_valid, m_over);
                end
            end
            vectors++;
            if (k == 0 && dut.g_lane[1].u_lane.sr_reg !== m_hold) begin
                miscompares++;
                $display("FAIL fault_sr_scrub: got sr=%b, want %b", dut.g_lane[1].u_lane.sr_reg, m_hold);
            end else if (k == 1 && dut.g_lane[2].u_lane.valid_reg !== m_valid) begin
                miscompares++;
                $display("FAIL fault_valid_scrub: got v=%b, want %b", dut.g_lane[2].u_lane.valid_reg, m_valid);
            end
`ifdef TMR_FAULT_FLAG_EN
            vectors++;
            if (fault_cnt != 1) begin
                miscompares++;
                $display("FAIL fault%0d_flag_cycles: got %0d, want 1", k, fault_cnt);
            end
`endif
            $display("test_fault_injection: replica upset %0d scrubbed, word %b held", k, parallel_out);
        end
        idle(1, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_restart();
        test_fault_injection();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
